// File: rtl/csr_file.sv
// Machine-mode CSR file: register storage, trap-entry update and combinational read port for decode.
// Define CSR_COUNTERS_EN to build in the 64-bit mcycle/minstret counters.
module csr_file #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] MHARTID_VAL = 32'h0,
  parameter logic [XLEN-1:0] MISA_VAL    = 32'h4000_0100
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            csr_wbk_v_i,
  input  logic [11:0]     csr_adr_i,
  input  logic [XLEN-1:0] csr_data_i,
  input  logic            exception_i,
  input  logic [XLEN-1:0] mcause_i,
  input  logic [XLEN-1:0] mtval_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [1:0]      core_mode_i,
  input  logic            retire_v_i,
  input  logic [11:0]     csr_rd_adr_i,
  output logic [XLEN-1:0] csr_rd_data_o,
  output logic            csr_rd_ill_o,
  output logic [XLEN-1:0] mstatus_q_o,
  output logic [XLEN-1:0] mtvec_q_o,
  output logic [XLEN-1:0] mepc_q_o
);

  localparam logic [11:0] ADR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADR_MISA      = 12'h301;
  localparam logic [11:0] ADR_MTVEC     = 12'h305;
  localparam logic [11:0] ADR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADR_MEPC      = 12'h341;
  localparam logic [11:0] ADR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADR_MTVAL     = 12'h343;
  localparam logic [11:0] ADR_MHARTID   = 12'hF14;
  localparam logic [11:0] ADR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADR_MINSTRETH = 12'hB82;

  // Writable mstatus fields: MPP[12:11], MPIE[7], MIE[3].
  localparam logic [XLEN-1:0] MSTATUS_MASK  = XLEN'(32'h0000_1888);
  localparam logic [XLEN-1:0] MSTATUS_RESET = XLEN'(32'h0000_1800);

  logic [XLEN-1:0] mstatus_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [XLEN-1:0] trap_mstatus;
  logic            wr_en;

  // A trap in the same cycle cancels the write regardless of its address.
  assign wr_en = csr_wbk_v_i & ~exception_i;

  always_comb begin
    trap_mstatus        = '0;
    trap_mstatus[12:11] = core_mode_i;
    trap_mstatus[7]     = mstatus_q[3];
  end

  // NOTE: sequential state uses non-blocking assignments and is cleared asynchronously by reset_n.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mstatus_q  <= MSTATUS_RESET;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (exception_i) begin
      mstatus_q <= trap_mstatus;
      mepc_q    <= {mepc_i[XLEN-1:2], 2'b00};
      mcause_q  <= mcause_i;
      mtval_q   <= mtval_i;
    end else if (wr_en) begin
      case (csr_adr_i)
        ADR_MSTATUS:  mstatus_q  <= csr_data_i & MSTATUS_MASK;
        ADR_MTVEC:    mtvec_q    <= {csr_data_i[XLEN-1:2], 2'b00};
        ADR_MSCRATCH: mscratch_q <= csr_data_i;
        ADR_MEPC:     mepc_q     <= {csr_data_i[XLEN-1:2], 2'b00};
        ADR_MCAUSE:   mcause_q   <= csr_data_i;
        ADR_MTVAL:    mtval_q    <= csr_data_i;
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  logic [63:0] mcycle_q, minstret_q;

  // A write to either half replaces that half and skips the counter's increment this cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr_en && csr_adr_i == ADR_MCYCLE)         mcycle_q[31:0]  <= csr_data_i;
      else if (wr_en && csr_adr_i == ADR_MCYCLEH)   mcycle_q[63:32] <= csr_data_i;
      else                                          mcycle_q        <= mcycle_q + 64'd1;

      if (wr_en && csr_adr_i == ADR_MINSTRET)       minstret_q[31:0]  <= csr_data_i;
      else if (wr_en && csr_adr_i == ADR_MINSTRETH) minstret_q[63:32] <= csr_data_i;
      else if (retire_v_i)                          minstret_q        <= minstret_q + 64'd1;
    end
  end
`else
  logic unused_retire;
  assign unused_retire = retire_v_i;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    csr_rd_data_o = '0;
    csr_rd_ill_o  = 1'b0;
    case (csr_rd_adr_i)
      ADR_MSTATUS:   csr_rd_data_o = mstatus_q;
      ADR_MISA:      csr_rd_data_o = MISA_VAL;
      ADR_MTVEC:     csr_rd_data_o = mtvec_q;
      ADR_MSCRATCH:  csr_rd_data_o = mscratch_q;
      ADR_MEPC:      csr_rd_data_o = mepc_q;
      ADR_MCAUSE:    csr_rd_data_o = mcause_q;
      ADR_MTVAL:     csr_rd_data_o = mtval_q;
      ADR_MHARTID:   csr_rd_data_o = MHARTID_VAL;
`ifdef CSR_COUNTERS_EN
      ADR_MCYCLE:    csr_rd_data_o = mcycle_q[31:0];
      ADR_MCYCLEH:   csr_rd_data_o = mcycle_q[63:32];
      ADR_MINSTRET:  csr_rd_data_o = minstret_q[31:0];
      ADR_MINSTRETH: csr_rd_data_o = minstret_q[63:32];
`endif
      default:       csr_rd_ill_o  = 1'b1;
    endcase
  end

  assign mstatus_q_o = mstatus_q;
  assign mtvec_q_o   = mtvec_q;
  assign mepc_q_o    = mepc_q;

endmodule

// File: tb/tb_csr_file.sv
// Directed self-checking bench for csr_file; counter checks depend on CSR_COUNTERS_EN.
module tb_csr_file;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        csr_wbk_v_i;
  logic [11:0] csr_adr_i;
  logic [31:0] csr_data_i;
  logic        exception_i;
  logic [31:0] mcause_i, mtval_i, mepc_i;
  logic [1:0]  core_mode_i;
  logic        retire_v_i;
  logic [11:0] csr_rd_adr_i;
  logic [31:0] csr_rd_data_o;
  logic        csr_rd_ill_o;
  logic [31:0] mstatus_q_o, mtvec_q_o, mepc_q_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csr_file dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .csr_wbk_v_i   (csr_wbk_v_i),
    .csr_adr_i     (csr_adr_i),
    .csr_data_i    (csr_data_i),
    .exception_i   (exception_i),
    .mcause_i      (mcause_i),
    .mtval_i       (mtval_i),
    .mepc_i        (mepc_i),
    .core_mode_i   (core_mode_i),
    .retire_v_i    (retire_v_i),
    .csr_rd_adr_i  (csr_rd_adr_i),
    .csr_rd_data_o (csr_rd_data_o),
    .csr_rd_ill_o  (csr_rd_ill_o),
    .mstatus_q_o   (mstatus_q_o),
    .mtvec_q_o     (mtvec_q_o),
    .mepc_q_o      (mepc_q_o)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    csr_wbk_v_i = 1'b0;
    exception_i = 1'b0;
    retire_v_i  = 1'b0;
  endtask

  task automatic csr_write(input logic [11:0] adr, input logic [31:0] data);
    csr_wbk_v_i = 1'b1;
    csr_adr_i   = adr;
    csr_data_i  = data;
    step();
    idle();
  endtask

  task automatic read_check(input string tag, input logic [11:0] adr,
                            input logic [31:0] exp_data, input logic exp_ill);
    csr_rd_adr_i = adr;
    #1;
    check({tag, "_data"}, csr_rd_data_o, exp_data);
    check({tag, "_ill"}, 32'(csr_rd_ill_o), 32'(exp_ill));
  endtask

  initial begin
    reset_n      = 1'b0;
    csr_wbk_v_i  = 1'b0;
    csr_adr_i    = '0;
    csr_data_i   = '0;
    exception_i  = 1'b0;
    mcause_i     = '0;
    mtval_i      = '0;
    mepc_i       = '0;
    core_mode_i  = '0;
    retire_v_i   = 1'b0;
    csr_rd_adr_i = 12'h300;
    #12;
    check("rst_mstatus", mstatus_q_o, 32'h0000_1800);
    check("rst_mtvec", mtvec_q_o, 32'h0);
    check("rst_mepc", mepc_q_o, 32'h0);
    reset_n = 1'b1;
    step();

    read_check("rd_mstatus", 12'h300, 32'h0000_1800, 1'b0);
    read_check("rd_unimpl", 12'h7C0, 32'h0, 1'b1);
    read_check("rd_misa", 12'h301, 32'h4000_0100, 1'b0);
    read_check("rd_mhartid", 12'hF14, 32'h0, 1'b0);
    read_check("rd_mscratch_rst", 12'h340, 32'h0, 1'b0);

    csr_write(12'h305, 32'h8000_0103);
    check("mtvec_align", mtvec_q_o, 32'h8000_0100);
    csr_write(12'h301, 32'h1234_5678);
    read_check("misa_ro", 12'h301, 32'h4000_0100, 1'b0);
    csr_write(12'h7C0, 32'hFFFF_FFFF);
    read_check("unimpl_wr", 12'h7C0, 32'h0, 1'b1);

    csr_write(12'h300, 32'hFFFF_FFFF);
    check("mstatus_mask", mstatus_q_o, 32'h0000_1888);
    csr_write(12'h341, 32'h0000_0203);
    check("mepc_align", mepc_q_o, 32'h0000_0200);
    csr_write(12'h340, 32'hA5A5_0001);
    read_check("mscratch_wr", 12'h340, 32'hA5A5_0001, 1'b0);
    csr_write(12'h340, 32'h0);

    // Plain trap with MIE set.
    csr_write(12'h300, 32'h0000_0008);
    check("mstatus_mie", mstatus_q_o, 32'h0000_0008);
    exception_i = 1'b1; mcause_i = 32'h2; mtval_i = 32'hDEAD; mepc_i = 32'h104; core_mode_i = 2'b11;
    step();
    idle();
    check("trap_mstatus", mstatus_q_o, 32'h0000_1880);
    check("trap_mepc", mepc_q_o, 32'h0000_0104);
    read_check("trap_mcause", 12'h342, 32'h2, 1'b0);
    read_check("trap_mtval", 12'h343, 32'hDEAD, 1'b0);

    // Trap coincident with a write to mscratch: write dropped.
    exception_i = 1'b1; mcause_i = 32'h5; mtval_i = 32'h11; mepc_i = 32'h207; core_mode_i = 2'b00;
    csr_wbk_v_i = 1'b1; csr_adr_i = 12'h340; csr_data_i = 32'h55;
    step();
    idle();
    read_check("coll_mscratch", 12'h340, 32'h0, 1'b0);
    check("coll_mepc", mepc_q_o, 32'h0000_0204);
    check("coll_mstatus", mstatus_q_o, 32'h0000_0000);
    read_check("coll_mcause", 12'h342, 32'h5, 1'b0);

    // Trap coincident with a write to mstatus itself: trap update wins.
    csr_write(12'h300, 32'h0000_0008);
    exception_i = 1'b1; mcause_i = 32'h7; mtval_i = 32'h0; mepc_i = 32'h300; core_mode_i = 2'b01;
    csr_wbk_v_i = 1'b1; csr_adr_i = 12'h300; csr_data_i = 32'h0000_1888;
    step();
    idle();
    check("coll2_mstatus", mstatus_q_o, 32'h0000_0880);

    csr_write(12'h340, 32'h55);
    read_check("mscratch_55", 12'h340, 32'h55, 1'b0);

    // Asynchronous reset mid-operation, away from any clock edge.
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_mtvec", mtvec_q_o, 32'h0);
    check("arst_mstatus", mstatus_q_o, 32'h0000_1800);
    read_check("arst_mscratch", 12'h340, 32'h0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

`ifdef CSR_COUNTERS_EN
    @(negedge clk);
    retire_v_i = 1'b1;
    repeat (5) @(negedge clk);
    retire_v_i = 1'b0;
    read_check("minstret", 12'hB02, 32'h5, 1'b0);
    read_check("minstreth", 12'hB82, 32'h0, 1'b0);

    csr_write(12'hB00, 32'hFFFF_FFFF);
    csr_write(12'hB80, 32'h0);
    read_check("mcycle_held", 12'hB00, 32'hFFFF_FFFF, 1'b0);
    step();
    step();
    read_check("mcycleh_carry", 12'hB80, 32'h1, 1'b0);
    read_check("mcycle_carry", 12'hB00, 32'h1, 1'b0);
`else
    read_check("no_minstret", 12'hB02, 32'h0, 1'b1);
    read_check("no_mcycle", 12'hB00, 32'h0, 1'b1);
    read_check("no_mcycleh", 12'hB80, 32'h0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
